// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: boot cycle, stall, redirect, trap vectoring and a
// circular return-address stack for call/return prediction.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h10),
    parameter int unsigned     STEP         = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0]  STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~(STEP_X - XLEN'(1));
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_en;
    logic [XLEN-1:0]  pc_inc;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    assign pc_inc = pc_q + STEP_X;

    // State and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            cnt_q      <= '0;
            top_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            cnt_q      <= cnt_d;
            top_q      <= top_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // RAS storage; the pointer advances before the write so top always names the newest entry
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_q[top_d] <= pc_inc;
        end
    end

    // Next-state: one action per edge, trap > redirect > ret > stall > increment
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        cnt_d      = cnt_q;
        top_d      = top_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        push_en    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            default: begin
                if (trap) begin
                    pc_d  = TRAP_VECTOR;
                    cnt_d = '0;
                end else if (redirect_valid) begin
                    pc_d = redirect_target & ALIGN_MASK;
                    if (call) begin
                        push_en = 1'b1;
                        top_d   = top_q + PTR_W'(1);
                        if (cnt_q == CNT_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end else if (ret) begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_q[top_q];
                        top_d = top_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
        endcase
    end

    assign pc            = pc_q;
    assign pc_valid      = pc_valid_q;
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CNT_FULL);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule
